// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control and instruction-memory signals of the fetch stage.
//   slave  - fetch stage side: takes start/branch/halt/LUT-write and imem read data,
//            drives imem address, instruction word, run/done/wrap_err status and
//            the RUN-cycle counter.
//   master - environment side (top level / testbench), the mirror image.
interface instr_fetch_if #(
    parameter int unsigned PCW  = 10,
    parameter int unsigned IW   = 9,
    parameter int unsigned LUTA = 4,
    parameter int unsigned CNTW = 16
);
    logic            start;
    logic [PCW-1:0]  start_addr;
    logic            branch;
    logic            cond_met;
    logic            halt;
    logic            lut_we;
    logic [LUTA-1:0] lut_addr;
    logic [PCW-1:0]  lut_data;
    logic [IW-1:0]   imem_data;
    logic [PCW-1:0]  imem_addr;
    logic [IW-1:0]   instr;
    logic            run;
    logic            done;
    logic            wrap_err;
    logic [CNTW-1:0] cycle_cnt;

    modport slave (
        input  start, start_addr, branch, cond_met, halt,
        input  lut_we, lut_addr, lut_data, imem_data,
        output imem_addr, instr, run, done, wrap_err, cycle_cnt
    );

    modport master (
        output start, start_addr, branch, cond_met, halt,
        output lut_we, lut_addr, lut_data, imem_data,
        input  imem_addr, instr, run, done, wrap_err, cycle_cnt
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program counter and instruction-fetch stage of the 9-bit CPU.
// Sequences the PC through Idle/Run/Halted, drives the instruction-memory
// address, forwards the fetched word to the decoder and resolves taken branches
// through a programmable branch-target LUT indexed by the low instruction bits.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset, clears all state including the LUT
//   bus  - instr_fetch_if slave modport (control inputs, imem, status outputs)
module instr_fetch #(
    parameter int unsigned PCW  = 10,
    parameter int unsigned IW   = 9,
    parameter int unsigned LUTA = 4,
    parameter int unsigned CNTW = 16
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);

    localparam int unsigned LutDepth = 2 ** LUTA;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

    state_e          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            wrap_q, wrap_d;
    logic [PCW-1:0]  lut_q [LutDepth];
    logic [LUTA-1:0] lut_idx;

    assign lut_idx = bus.imem_data[LUTA-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (bus.start) begin
                    state_d = StRun;
                    pc_d    = bus.start_addr;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            StRun: begin
                // The halt cycle is itself a RUN cycle and is counted.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (bus.halt) begin
                    state_d = StHalted;
                end else if (bus.branch && bus.cond_met) begin
                    // Reads the registered LUT, so a same-cycle write is not yet visible.
                    pc_d = lut_q[lut_idx];
                end else begin
                    pc_d = pc_q + 1'b1;
                    if (pc_q == '1) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // Branch-target LUT, writable in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LutDepth; i++) begin
                lut_q[i] <= '0;
            end
        end else if (bus.lut_we) begin
            lut_q[bus.lut_addr] <= bus.lut_data;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.instr     = bus.imem_data;
    assign bus.run       = (state_q == StRun);
    assign bus.done      = (state_q == StHalted);
    assign bus.wrap_err  = wrap_q;
    assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch. A small
// instruction memory array feeds imem_data; branch/cond_met/halt are driven
// directly in place of the decoder and ALU. Expected values are hand-computed.
module tb_instr_fetch;

    logic clk;
    logic rst;

    instr_fetch_if #(.PCW(10), .IW(9), .LUTA(4), .CNTW(16)) bus ();

    instr_fetch #(.PCW(10), .IW(9), .LUTA(4), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [8:0] imem [1024];
    assign bus.imem_data = imem[bus.imem_addr];

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 1024; i++) begin
            imem[i] = 9'h100 | 9'(i & 8'hff);
        end
        // Low nibble 3 selects LUT entry 3 at these addresses.
        imem[10] = 9'h0a3;
        imem[11] = 9'h0b3;
        imem[12] = 9'h0c3;
        imem[20] = 9'h143;
        imem[30] = 9'h1e3;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.branch     = 1'b0;
        bus.cond_met   = 1'b0;
        bus.halt       = 1'b0;
        bus.lut_we     = 1'b0;
        bus.lut_addr   = '0;
        bus.lut_data   = '0;
        #12;
        check("rst_addr", 32'(bus.imem_addr), 0);
        check("rst_run", 32'(bus.run), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_wrap", 32'(bus.wrap_err), 0);
        check("rst_cnt", 32'(bus.cycle_cnt), 0);
        rst = 1'b0;
        step();
        check("idle_hold", 32'(bus.imem_addr), 0);
        check("idle_run", 32'(bus.run), 0);

        // Straight-line run 5..8 with halt at 8.
        bus.start      = 1'b1;
        bus.start_addr = 10'd5;
        step();
        bus.start = 1'b0;
        check("s_pc5", 32'(bus.imem_addr), 5);
        check("s_run", 32'(bus.run), 1);
        check("s_done", 32'(bus.done), 0);
        check("s_instr5", 32'(bus.instr), 32'h105);
        step();
        check("s_pc6", 32'(bus.imem_addr), 6);
        step();
        check("s_pc7", 32'(bus.imem_addr), 7);
        step();
        check("s_pc8", 32'(bus.imem_addr), 8);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("h_done", 32'(bus.done), 1);
        check("h_run", 32'(bus.run), 0);
        check("h_pc", 32'(bus.imem_addr), 8);
        check("h_cnt", 32'(bus.cycle_cnt), 4);
        step();
        check("h_pc_hold", 32'(bus.imem_addr), 8);
        check("h_cnt_hold", 32'(bus.cycle_cnt), 4);

        // LUT[3] = 20 written while halted, then restart at 9.
        bus.lut_we   = 1'b1;
        bus.lut_addr = 4'd3;
        bus.lut_data = 10'd20;
        step();
        bus.lut_we     = 1'b0;
        bus.start      = 1'b1;
        bus.start_addr = 10'd9;
        step();
        bus.start = 1'b0;
        check("b_pc9", 32'(bus.imem_addr), 9);
        check("b_cnt0", 32'(bus.cycle_cnt), 0);
        check("b_done0", 32'(bus.done), 0);
        step();
        check("b_pc10", 32'(bus.imem_addr), 10);
        bus.branch   = 1'b1;
        bus.cond_met = 1'b1;
        step();
        check("b_taken", 32'(bus.imem_addr), 20);
        // Halt together with a taken branch: halt wins.
        bus.halt = 1'b1;
        step();
        bus.halt     = 1'b0;
        bus.branch   = 1'b0;
        bus.cond_met = 1'b0;
        check("hb_pc", 32'(bus.imem_addr), 20);
        check("hb_done", 32'(bus.done), 1);

        // Not-taken branch at 11 falls through.
        bus.start      = 1'b1;
        bus.start_addr = 10'd11;
        step();
        bus.start = 1'b0;
        check("nt_pc11", 32'(bus.imem_addr), 11);
        bus.branch = 1'b1;
        step();
        check("nt_pc12", 32'(bus.imem_addr), 12);

        // Same-cycle LUT write and lookup of entry 3: old value used.
        bus.cond_met = 1'b1;
        bus.lut_we   = 1'b1;
        bus.lut_addr = 4'd3;
        bus.lut_data = 10'd40;
        step();
        bus.lut_we = 1'b0;
        check("wr_old", 32'(bus.imem_addr), 20);
        step();
        bus.branch   = 1'b0;
        bus.cond_met = 1'b0;
        check("wr_new", 32'(bus.imem_addr), 40);
        step();
        check("seq_41", 32'(bus.imem_addr), 41);

        // Start during RUN is ignored.
        bus.start      = 1'b1;
        bus.start_addr = 10'd0;
        step();
        bus.start = 1'b0;
        check("run_start_pc", 32'(bus.imem_addr), 42);
        check("run_start_run", 32'(bus.run), 1);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("h42_done", 32'(bus.done), 1);

        // PC wrap 1022, 1023, 0, 1.
        bus.start      = 1'b1;
        bus.start_addr = 10'd1022;
        step();
        bus.start = 1'b0;
        check("w_1022", 32'(bus.imem_addr), 1022);
        check("w_err0", 32'(bus.wrap_err), 0);
        step();
        check("w_1023", 32'(bus.imem_addr), 1023);
        check("w_err1023", 32'(bus.wrap_err), 0);
        step();
        check("w_0", 32'(bus.imem_addr), 0);
        check("w_err_set", 32'(bus.wrap_err), 1);
        step();
        check("w_1", 32'(bus.imem_addr), 1);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("w_halt_err", 32'(bus.wrap_err), 1);
        check("w_halt_cnt", 32'(bus.cycle_cnt), 4);

        // Start from HALTED at address 0 clears wrap_err and the counter.
        bus.start      = 1'b1;
        bus.start_addr = 10'd0;
        step();
        bus.start = 1'b0;
        check("r0_pc", 32'(bus.imem_addr), 0);
        check("r0_run", 32'(bus.run), 1);
        check("r0_err", 32'(bus.wrap_err), 0);
        check("r0_cnt", 32'(bus.cycle_cnt), 0);
        for (int i = 0; i < 7; i++) begin
            step();
        end
        check("r7_pc", 32'(bus.imem_addr), 7);
        check("r7_cnt", 32'(bus.cycle_cnt), 7);

        // Asynchronous reset between edges.
        #1;
        rst = 1'b1;
        #1;
        check("ar_run", 32'(bus.run), 0);
        check("ar_pc", 32'(bus.imem_addr), 0);
        check("ar_cnt", 32'(bus.cycle_cnt), 0);
        #1;
        rst = 1'b0;
        step();
        check("ar_idle_pc", 32'(bus.imem_addr), 0);
        check("ar_idle_run", 32'(bus.run), 0);

        // LUT cleared by reset: taken branch via entry 3 goes to 0.
        bus.start      = 1'b1;
        bus.start_addr = 10'd30;
        step();
        bus.start = 1'b0;
        check("lc_pc30", 32'(bus.imem_addr), 30);
        bus.branch   = 1'b1;
        bus.cond_met = 1'b1;
        step();
        bus.branch   = 1'b0;
        bus.cond_met = 1'b0;
        check("lc_target", 32'(bus.imem_addr), 0);
        step();
        check("lc_next", 32'(bus.imem_addr), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
